// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin mux arbiter:
//   SEL_W    - width of the mux select
//   N_REQ    - number of requesters (2**SEL_W)
//   LAST_RST - reset value of the last-owner register, so the very first
//              scan after reset begins at requester 0
//   state_t  - arbiter FSM states
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int SEL_W = 4;
  localparam int N_REQ = 2 ** SEL_W;

  localparam logic [SEL_W-1:0] LAST_RST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: finds the first set request bit scanning
// upward from i_last+1, wrapping around, so the previous owner is the very
// last candidate considered.
// Ports:
//   i_req  [N_REQ-1:0] request lines
//   i_last [SEL_W-1:0] index of the previous owner
//   o_idx  [SEL_W-1:0] index of the winning requester (0 when none)
//   o_any              high when at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_last,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_pos;

  // Walk the candidates in priority order. The SEL_W-bit addition wraps
  // naturally modulo N_REQ, and the final step (offset N_REQ) lands back on
  // i_last itself, which lets a lone previous owner win again.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos = i_last + SEL_W'(k);
      if (!o_any && i_req[w_pos]) begin
        o_idx = w_pos;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter sharing one 16:1 bit-select mux among 16 requesters.
// A grant is held until the owner pulses i_done or drops its request, then
// one GAP cycle with no grant separates consecutive owners so the mux output
// never changes while a grant is asserted.
//
// Optional feature (compile-time macro MUX_ARB_TIMEOUT_EN): a hold counter
// revokes a grant after HOLD_MAX cycles in GRANT and pulses o_timeout.
// Without the macro no counter exists and o_timeout is constant 0.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst              asynchronous active-high reset
//   i_req  [N_REQ-1:0] level-sensitive request lines
//   i_done             end-of-transfer pulse from the current owner
//   o_sel  [SEL_W-1:0] registered mux select (current or last owner)
//   o_grant[N_REQ-1:0] registered one-hot grant, zero when nobody owns
//   o_busy             high while in GRANT
//   o_timeout          one-cycle pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SEL_W    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2**SEL_W-1:0]   i_req,
  input  logic                  i_done,
  output logic [SEL_W-1:0]      o_sel,
  output logic [2**SEL_W-1:0]   o_grant,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int N_REQ = 2 ** SEL_W;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [N_REQ-1:0]   r_grant;
  logic               r_busy;
  logic               r_timeout;
  logic [SEL_W-1:0]   r_last;

  logic [SEL_W-1:0]   w_idx;
  logic               w_any;
  logic               w_exit;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  logic [HOLD_W-1:0]  r_hold;
`endif

  rr_pick u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Normal release: owner signals completion or withdraws its request.
  // Both in the same cycle still count as a single exit.
  assign w_exit = i_done | ~i_req[r_sel];

  // Arbiter FSM with all outputs registered. Requests are only looked at in
  // IDLE, so anything arriving during GRANT or GAP waits for the next scan.
  // On any exit the owner index is remembered in r_last so the next scan
  // starts just above it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= SEL_W'(LAST_RST);
`ifdef MUX_ARB_TIMEOUT_EN
      r_hold    <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_idx;
            r_grant <= N_REQ'(1) << w_idx;
            r_busy  <= 1'b1;
            r_state <= GRANT;
`ifdef MUX_ARB_TIMEOUT_EN
            r_hold  <= '0;
`endif
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (w_exit) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_sel;
            r_state <= GAP;
`ifdef MUX_ARB_TIMEOUT_EN
          end else if (r_hold == HOLD_W'(HOLD_MAX - 1)) begin
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_last    <= r_sel;
            r_timeout <= 1'b1;
            r_state   <= GAP;
          end else begin
            r_hold <= r_hold + 1'b1;
`endif
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_sel     = r_sel;
  assign o_grant   = r_grant;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Scoreboard bench for mux_rr_arbiter. The driver applies inputs on the
// falling edge, steps a behavioural model (owner index / gap flag / last
// owner as plain integers) and queues the outputs expected after the next
// rising edge. An independent monitor pops and compares after each rising
// edge. Honours MUX_ARB_TIMEOUT_EN so the model matches either build.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int HOLD_MAX = 8;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        busy;
  logic        timeout;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        busy;
    logic        to;
  } exp_t;

  exp_t expQ[$];

  int checks   = 0;
  int failures = 0;

  int mOwner;
  int mLast;
  int mSel;
  int mHold;
  bit mGap;

  mux_rr_arbiter #(
    .SEL_W    (4),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_done    (done),
    .o_sel     (sel),
    .o_grant   (grant),
    .o_busy    (busy),
    .o_timeout (timeout)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation
  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic void modelReset();
    mOwner = -1;
    mLast  = 15;
    mSel   = 0;
    mHold  = 0;
    mGap   = 1'b0;
  endfunction

  // Behavioural step: what the arbiter shows after the next rising edge
  function automatic void modelStep(input logic [15:0] rq, input logic dn);
    exp_t e;
    bit   to;
    to = 1'b0;
    if (mOwner >= 0) begin
      mHold++;
      if (dn || !rq[mOwner]) begin
        mLast  = mOwner;
        mOwner = -1;
        mGap   = 1'b1;
      end
`ifdef MUX_ARB_TIMEOUT_EN
      else if (mHold == HOLD_MAX) begin
        mLast  = mOwner;
        mOwner = -1;
        mGap   = 1'b1;
        to     = 1'b1;
      end
`endif
    end else if (mGap) begin
      mGap = 1'b0;
    end else begin
      for (int k = 1; k <= 16; k++) begin
        int c;
        c = (mLast + k) % 16;
        if (rq[c]) begin
          mOwner = c;
          mSel   = c;
          mHold  = 0;
          break;
        end
      end
    end
    e.sel   = 4'(mSel);
    e.grant = (mOwner >= 0) ? (16'd1 << mOwner) : 16'd0;
    e.busy  = (mOwner >= 0);
    e.to    = to;
    expQ.push_back(e);
  endfunction

  // One cycle of stimulus: drive on the falling edge, queue expectation
  task automatic applyStimulus(input logic [15:0] rq, input logic dn);
    @(negedge clk);
    req  = rq;
    done = dn;
    modelStep(rq, dn);
  endtask

  // Release reset on a falling edge and drive the first cycle right away
  task automatic releaseReset(input logic [15:0] rq);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    req  = rq;
    done = 1'b0;
    modelStep(rq, 1'b0);
  endtask

  // Monitor: compare whatever the DUT shows just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sel",     16'(sel),     16'(e.sel));
        checkOutput("grant",   grant,        e.grant);
        checkOutput("busy",    16'(busy),    16'(e.busy));
        checkOutput("timeout", 16'(timeout), 16'(e.to));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] mask;
    modelReset();
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;

    // Outputs are held clear while reset is asserted, even with requests
    #12;
    checkOutput("rst_sel",     16'(sel),     16'h0);
    checkOutput("rst_grant",   grant,        16'h0);
    checkOutput("rst_busy",    16'(busy),    16'h0);
    checkOutput("rst_timeout", 16'(timeout), 16'h0);

    // First scan after reset starts at requester 0
    releaseReset(16'hFFFF);
    applyStimulus(16'hFFFF, 1'b1);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);

    // Two requesters alternate, done pulsed whenever a grant is held
    for (int i = 0; i < 15; i++) applyStimulus(16'h8001, (mOwner >= 0));
    for (int i = 0; i < 3; i++)  applyStimulus(16'h0000, 1'b0);

    // Owner 4 withdraws after five cycles in GRANT
    for (int i = 0; i < 6; i++) applyStimulus(16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(16'h0000, 1'b0);

    // Owner 3 finishes while requester 7 arrives in the same cycle
    for (int i = 0; i < 2; i++) applyStimulus(16'h0008, 1'b0);
    applyStimulus(16'h0088, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0080, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(16'h0000, 1'b0);

    // Single requester held with no done: timeout build revokes and regrants
    for (int i = 0; i < 100; i++) applyStimulus(16'h0004, 1'b0);
    for (int i = 0; i < 3; i++)   applyStimulus(16'h0000, 1'b0);

    // done outside GRANT is ignored
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h0000, 1'b1);

    // Randomized traffic with sparse request masks and occasional done
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) mask = 16'($urandom);
      applyStimulus(16'($urandom) & mask, ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 3; i++) applyStimulus(16'h0000, 1'b0);

    // Get requester 9 into GRANT, then hit reset between clock edges
    for (int i = 0; i < 6 && mOwner != 9; i++) applyStimulus(16'h0200, 1'b0);
    applyStimulus(16'h0200, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_sel",   16'(sel),  16'h0);
    checkOutput("arst_grant", grant,     16'h0);
    checkOutput("arst_busy",  16'(busy), 16'h0);
    @(negedge clk);
    @(negedge clk);
    releaseReset(16'h0200);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0200, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(16'h0000, 1'b0);

    // Let the monitor drain the scoreboard
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 16'(expQ.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 16:1 bit-select mux among 16 requesters. It drives the 4-bit select of the downstream mux and a one-hot grant vector back to the requesters. A grant is held until the owner signals completion or withdraws its request. The block sits directly in front of the mux's `sel` input in the datapath.

## Interface
Parameters:
- `SEL_W`, 4: select width; the number of requesters `N_REQ` = 2**SEL_W. 16 is the only verified configuration.
- `HOLD_MAX`, 8: maximum number of cycles in GRANT; used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  16  request lines; bit i is requester i; level-sensitive.
- `done`  in  1  pulse from the current owner marking the end of its transfer.
- `sel`  out  4  registered mux select; index of the current or last owner.
- `grant`  out  16  registered one-hot grant; all zeros when nobody owns the mux.
- `busy`  out  1  high while in GRANT.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
State machine, three states:
- IDLE:
  - If `req` is nonzero, pick a winner, load `sel` and `grant`, and go to GRANT.
  - Otherwise stay in IDLE and keep `grant`=0.
- GRANT:
  - Hold `sel` and `grant` stable.
  - Exit to GAP when `done`=1 or `req[sel]`=0.
  - On exit: `grant` clears, `last` <= `sel`.
- GAP:
  - Exactly one cycle with `grant`=0; `sel` keeps its value.
  - Then go to IDLE.
  - The gap separates consecutive owners so the mux output never changes while a grant is asserted.

Round-robin rule:
- Winner = first set `req` bit scanning from `last`+1 upward, wrapping modulo 16.
- `last` resets to 15, so the first scan starts at requester 0.
- Requests that arrive during GRANT or GAP are only considered in IDLE.

Boundary conditions:
- `done` in IDLE or GAP is ignored.
- If the only requester is the previous owner, it wins again after the gap.
- `done` together with `req[sel]` dropping in the same cycle counts as one exit.
- `req` bits of non-owners may toggle freely during GRANT with no effect.
- `rst` asserted mid-grant: outputs clear immediately (asynchronously), the state goes to IDLE and `last`=15.

## Timing
- Reset values: `sel`=0, `grant`=0, `busy`=0, `timeout`=0; state IDLE; `last`=15.
- Request to grant latency: `req` sampled in IDLE at edge N gives `grant`/`sel` valid after edge N.
- Exit latency: `done` sampled at edge N gives `grant`=0 after edge N. The earliest next grant follows edge N+2.
- Minimum arbitration period: 3 cycles per owner (one GRANT cycle, GAP, IDLE).
- `busy` equals (state == GRANT), registered.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - A hold counter counts cycles in GRANT.
  - When it reaches HOLD_MAX with no exit, the grant is revoked, `timeout` pulses for one cycle, and the FSM enters GAP. `last` updates as on a normal exit.
  - An exit via `done` or a `req` drop in the same cycle takes precedence; no `timeout` pulse is produced.
- Not defined: no counter is instantiated and `timeout` is tied 0. A grant is held indefinitely.

## Structure
- Package `mux_arb_pkg` holds:
  - the state enum (IDLE, GRANT, GAP)
  - the `SEL_W` and `N_REQ` constants
  - the reset value of `last`.
- Sub-module `rr_pick`: combinational rotate plus priority encoder.
  - Inputs: `req`[15:0] and `last`[3:0].
  - Outputs: `idx`[3:0] and `any`.
  - Instantiated once in `mux_rr_arbiter`.

## Test plan
- Reset with `req`=16'hFFFF held → `sel`=0, `grant`=0 during reset; after release, `grant`=16'h0001 and `sel`=0 one edge later.
- `req`=16'h8001 held, `done` pulsed in every grant → grant order 0, 15, 0, 15, … with one zero-grant GAP cycle between grants.
- `req`=16'h0010 then `req[4]` drops after 5 cycles in GRANT → `grant` clears on the next edge; `sel` stays 4; `busy` falls.
- Owner 3 in GRANT, `req[7]` rises and `done` pulses in the same cycle → `grant` cleared, one GAP cycle, then `sel`=7.
- With `MUX_ARB_TIMEOUT_EN` and HOLD_MAX=8: `req`=16'h0004 held, no `done` → `timeout` pulses after 8 GRANT cycles, GAP follows, then requester 2 is re-granted. Without the macro, the same stimulus keeps the grant for 100 cycles and `timeout` stays 0.
- Assert `rst` mid-GRANT with `sel`=9 → outputs 0 with no clock edge; after release with `req`=16'h0200, `sel`=9 is re-granted (scan starts at 0).
